// File: rtl/alu_rs.sv
// Reservation station for the integer ALU. It holds dispatched micro-ops,
// snoops both result buses for missing operands, and issues the lowest ready entry.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear,
  input  logic             disp_valid,
  input  logic [10:0]      disp_op,
  input  logic             disp_qj_busy,
  input  logic             disp_qk_busy,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic [ROB_W-1:0] disp_qk,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic [31:0]      disp_pc,
  input  logic [31:0]      disp_imm,
  input  logic [ROB_W-1:0] disp_rob_id,
  output logic             full,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_rob_id,
  input  logic [31:0]      cdb_alu_value,
  input  logic             cdb_lsb_valid,
  input  logic [ROB_W-1:0] cdb_lsb_rob_id,
  input  logic [31:0]      cdb_lsb_value,
  output logic             alu_yes,
  output logic [10:0]      alu_op,
  output logic [31:0]      alu_v1,
  output logic [31:0]      alu_v2,
  output logic [31:0]      alu_pc,
  output logic [31:0]      alu_imm,
  output logic [ROB_W-1:0] alu_rob_id
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_busy;
  logic [RS_SIZE-1:0] qk_busy;
  logic [10:0]        op_q  [RS_SIZE];
  logic [ROB_W-1:0]   qj_q  [RS_SIZE];
  logic [ROB_W-1:0]   qk_q  [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];
  logic [31:0]        vj_q  [RS_SIZE];
  logic [31:0]        vk_q  [RS_SIZE];
  logic [31:0]        pc_q  [RS_SIZE];
  logic [31:0]        imm_q [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;

  // Returns {still_busy, value}; the LSB bus wins when both buses carry the tag.
  function automatic logic [32:0] resolve(input logic busy_in,
                                          input logic [ROB_W-1:0] tag,
                                          input logic [31:0] val);
    logic [32:0] res;
    res = {busy_in, val};
    if (busy_in) begin
      if (cdb_lsb_valid && cdb_lsb_rob_id == tag)
        res = {1'b0, cdb_lsb_value};
      else if (cdb_alu_valid && cdb_alu_rob_id == tag)
        res = {1'b0, cdb_alu_value};
    end
    return res;
  endfunction

  assign full  = &busy;
  assign ready = busy & ~qj_busy & ~qk_busy;

  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_valid = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i])
        free_idx = IDX_W'(i);
      if (ready[i]) begin
        sel_idx   = IDX_W'(i);
        sel_valid = 1'b1;
      end
    end
  end

  // The dispatch slot is taken from pre-edge busy bits, so a slot freed by issue waits a cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      busy       <= '0;
      alu_yes    <= 1'b0;
      alu_op     <= '0;
      alu_v1     <= '0;
      alu_v2     <= '0;
      alu_pc     <= '0;
      alu_imm    <= '0;
      alu_rob_id <= '0;
    end else begin
      alu_yes <= sel_valid;
      if (sel_valid) begin
        alu_op         <= op_q[sel_idx];
        alu_v1         <= vj_q[sel_idx];
        alu_v2         <= vk_q[sel_idx];
        alu_pc         <= pc_q[sel_idx];
        alu_imm        <= imm_q[sel_idx];
        alu_rob_id     <= rob_q[sel_idx];
        busy[sel_idx]  <= 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          {qj_busy[i], vj_q[i]} <= resolve(qj_busy[i], qj_q[i], vj_q[i]);
          {qk_busy[i], vk_q[i]} <= resolve(qk_busy[i], qk_q[i], vk_q[i]);
        end
      end
      if (disp_valid && !full) begin
        busy[free_idx]                  <= 1'b1;
        op_q[free_idx]                  <= disp_op;
        qj_q[free_idx]                  <= disp_qj;
        qk_q[free_idx]                  <= disp_qk;
        pc_q[free_idx]                  <= disp_pc;
        imm_q[free_idx]                 <= disp_imm;
        rob_q[free_idx]                 <= disp_rob_id;
        {qj_busy[free_idx], vj_q[free_idx]} <= resolve(disp_qj_busy, disp_qj, disp_vj);
        {qk_busy[free_idx], vk_q[free_idx]} <= resolve(disp_qk_busy, disp_qk, disp_vk);
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios followed by random traffic, every cycle
// compared against a slot-array reference model of the reservation station.
module tb_alu_rs;

  localparam int RS_SIZE = 8;
  localparam int ROB_W   = 4;

  logic             clk_in = 1'b0;
  logic             rst_in, clear;
  logic             disp_valid, disp_qj_busy, disp_qk_busy;
  logic [10:0]      disp_op;
  logic [ROB_W-1:0] disp_qj, disp_qk, disp_rob_id;
  logic [31:0]      disp_vj, disp_vk, disp_pc, disp_imm;
  logic             full;
  logic             cdb_alu_valid, cdb_lsb_valid;
  logic [ROB_W-1:0] cdb_alu_rob_id, cdb_lsb_rob_id;
  logic [31:0]      cdb_alu_value, cdb_lsb_value;
  logic             alu_yes;
  logic [10:0]      alu_op;
  logic [31:0]      alu_v1, alu_v2, alu_pc, alu_imm;
  logic [ROB_W-1:0] alu_rob_id;

  alu_rs #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .clear(clear),
    .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_rob_id(disp_rob_id),
    .full(full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_alu_value(cdb_alu_value),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_value(cdb_lsb_value),
    .alu_yes(alu_yes), .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2),
    .alu_pc(alu_pc), .alu_imm(alu_imm), .alu_rob_id(alu_rob_id)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          v;
    logic [10:0] op;
    bit          jb;
    logic [3:0]  qj;
    logic [31:0] vj;
    bit          kb;
    logic [3:0]  qk;
    logic [31:0] vk;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  rob;
  } ent_t;

  ent_t        m [RS_SIZE];
  logic        exp_yes;
  logic [10:0] exp_op;
  logic [31:0] exp_v1, exp_v2, exp_pc, exp_imm;
  logic [3:0]  exp_rob;
  int          n_checks = 0;
  int          n_fail = 0;

  localparam logic [10:0] OP_ADDI = 11'b0_000_0010011;
  localparam logic [10:0] OP_ADD  = 11'b0_000_0110011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_full();
    for (int i = 0; i < RS_SIZE; i++)
      if (!m[i].v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit bus_hit(input logic [3:0] tag, output logic [31:0] val);
    val = '0;
    if (cdb_lsb_valid && cdb_lsb_rob_id == tag) begin val = cdb_lsb_value; return 1'b1; end
    if (cdb_alu_valid && cdb_alu_rob_id == tag) begin val = cdb_alu_value; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < RS_SIZE; i++) m[i].v = 1'b0;
    exp_yes = 0; exp_op = '0; exp_v1 = '0; exp_v2 = '0;
    exp_pc = '0; exp_imm = '0; exp_rob = '0;
  endfunction

  // One clock of the reference: issue oldest-index ready, snoop, then dispatch into a pre-edge free slot.
  function automatic void model_step();
    bit          was_full;
    int          free;
    logic [31:0] t;
    if (rst_in || clear) begin
      model_clear();
      return;
    end
    was_full = model_full();
    free = -1;
    for (int i = 0; i < RS_SIZE; i++)
      if (!m[i].v && free < 0) free = i;
    exp_yes = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (m[i].v && !m[i].jb && !m[i].kb) begin
        exp_yes = 1'b1; exp_op = m[i].op; exp_v1 = m[i].vj; exp_v2 = m[i].vk;
        exp_pc = m[i].pc; exp_imm = m[i].imm; exp_rob = m[i].rob;
        m[i].v = 1'b0;
        break;
      end
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      if (m[i].v && m[i].jb && bus_hit(m[i].qj, t)) begin m[i].jb = 0; m[i].vj = t; end
      if (m[i].v && m[i].kb && bus_hit(m[i].qk, t)) begin m[i].kb = 0; m[i].vk = t; end
    end
    if (disp_valid && !was_full) begin
      m[free].v = 1'b1; m[free].op = disp_op; m[free].pc = disp_pc; m[free].imm = disp_imm;
      m[free].rob = disp_rob_id;
      m[free].jb = disp_qj_busy; m[free].qj = disp_qj; m[free].vj = disp_vj;
      m[free].kb = disp_qk_busy; m[free].qk = disp_qk; m[free].vk = disp_vk;
      if (m[free].jb && bus_hit(m[free].qj, t)) begin m[free].jb = 0; m[free].vj = t; end
      if (m[free].kb && bus_hit(m[free].qk, t)) begin m[free].kb = 0; m[free].vk = t; end
    end
  endfunction

  task automatic applyStimulus(input logic [10:0] op, input bit jb, input logic [3:0] qj,
                               input logic [31:0] vj, input bit kb, input logic [3:0] qk,
                               input logic [31:0] vk, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [3:0] rob);
    disp_valid = 1'b1; disp_op = op; disp_qj_busy = jb; disp_qj = qj; disp_vj = vj;
    disp_qk_busy = kb; disp_qk = qk; disp_vk = vk; disp_pc = pc; disp_imm = imm;
    disp_rob_id = rob;
  endtask

  task automatic cdbAlu(input logic [3:0] tag, input logic [31:0] val);
    cdb_alu_valid = 1'b1; cdb_alu_rob_id = tag; cdb_alu_value = val;
  endtask

  task automatic cdbLsb(input logic [3:0] tag, input logic [31:0] val);
    cdb_lsb_valid = 1'b1; cdb_lsb_rob_id = tag; cdb_lsb_value = val;
  endtask

  // Advance one clock, checking full beforehand and the whole issue port afterwards.
  task automatic checkOutput();
    chk("full", full, model_full());
    model_step();
    @(posedge clk_in);
    #1;
    chk("alu_yes", alu_yes, exp_yes);
    chk("alu_op", alu_op, exp_op);
    chk("alu_v1", alu_v1, exp_v1);
    chk("alu_v2", alu_v2, exp_v2);
    chk("alu_pc", alu_pc, exp_pc);
    chk("alu_imm", alu_imm, exp_imm);
    chk("alu_rob_id", alu_rob_id, exp_rob);
    disp_valid = 1'b0; cdb_alu_valid = 1'b0; cdb_lsb_valid = 1'b0; clear = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; clear = 1'b0; disp_valid = 1'b0;
    disp_op = '0; disp_qj_busy = 0; disp_qk_busy = 0; disp_qj = '0; disp_qk = '0;
    disp_vj = '0; disp_vk = '0; disp_pc = '0; disp_imm = '0; disp_rob_id = '0;
    cdb_alu_valid = 0; cdb_alu_rob_id = '0; cdb_alu_value = '0;
    cdb_lsb_valid = 0; cdb_lsb_rob_id = '0; cdb_lsb_value = '0;
    model_clear();
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_yes", alu_yes, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_v1", alu_v1, 0);
    chk("rst_rob", alu_rob_id, 0);
    chk("rst_full", full, 0);
    rst_in = 1'b0;

    applyStimulus(OP_ADDI, 0, 0, 32'd5, 0, 0, 32'd0, 32'h100, 32'd7, 4'd3);
    checkOutput();
    checkOutput();
    chk("addi_yes", alu_yes, 1);
    chk("addi_v1", alu_v1, 5);
    chk("addi_imm", alu_imm, 7);
    chk("addi_rob", alu_rob_id, 3);
    checkOutput();
    chk("addi_pulse", alu_yes, 0);

    applyStimulus(OP_ADD, 1, 4'd2, 32'hDEAD, 0, 0, 32'd1, 32'h104, 32'd0, 4'd5);
    checkOutput();
    checkOutput();
    cdbAlu(4'd2, 32'h10);
    checkOutput();
    chk("cdb_wait_yes", alu_yes, 0);
    checkOutput();
    chk("cdb_yes", alu_yes, 1);
    chk("cdb_v1", alu_v1, 32'h10);

    applyStimulus(OP_ADD, 1, 4'd7, 32'h0, 1, 4'd7, 32'h0, 32'h108, 32'd0, 4'd6);
    cdbAlu(4'd7, 32'h44);
    cdbLsb(4'd7, 32'h33);
    checkOutput();
    checkOutput();
    chk("fwd_yes", alu_yes, 1);
    chk("fwd_lsb_prio_v1", alu_v1, 32'h33);
    chk("fwd_lsb_prio_v2", alu_v2, 32'h33);

    for (int i = 0; i < RS_SIZE; i++) begin
      applyStimulus(OP_ADD, 1, 4'd9, 32'h0, 0, 0, 32'(i * 3), 32'(i * 4), 32'd0, 4'(i));
      checkOutput();
    end
    chk("fill_full", full, 1);
    applyStimulus(OP_ADDI, 0, 0, 32'd1, 0, 0, 32'd1, 32'h0, 32'd1, 4'd15);
    checkOutput();
    chk("reject_yes", alu_yes, 0);
    cdbLsb(4'd9, 32'h99);
    checkOutput();
    for (int i = 0; i < RS_SIZE; i++) begin
      checkOutput();
      chk("drain_yes", alu_yes, 1);
      chk("drain_rob", alu_rob_id, 4'(i));
    end
    checkOutput();
    chk("drain_done", alu_yes, 0);

    applyStimulus(OP_ADD, 1, 4'd4, 32'h0, 1, 4'd6, 32'h0, 32'h200, 32'd0, 4'd10);
    checkOutput();
    cdbAlu(4'd4, 32'hA4);
    cdbLsb(4'd6, 32'hB6);
    checkOutput();
    chk("dual_wait", alu_yes, 0);
    checkOutput();
    chk("dual_yes", alu_yes, 1);
    chk("dual_v1", alu_v1, 32'hA4);
    chk("dual_v2", alu_v2, 32'hB6);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_ADD, 1, 4'd12, 32'h0, 0, 0, 32'h0, 32'h300, 32'd0, 4'(i));
      checkOutput();
    end
    clear = 1'b1;
    applyStimulus(OP_ADDI, 0, 0, 32'd1, 0, 0, 32'd2, 32'h0, 32'd3, 4'd11);
    cdbAlu(4'd12, 32'h12);
    checkOutput();
    chk("clr_yes", alu_yes, 0);
    chk("clr_full", full, 0);
    for (int i = 0; i < 4; i++) begin
      cdbAlu(4'd12, 32'h12);
      checkOutput();
      chk("clr_no_issue", alu_yes, 0);
    end

    for (int i = 0; i < RS_SIZE; i++) begin
      applyStimulus(OP_ADD, 1, 4'd13, 32'h0, 0, 0, 32'h0, 32'h400, 32'd0, 4'(i));
      checkOutput();
    end
    cdbLsb(4'd13, 32'h13);
    checkOutput();
    applyStimulus(OP_ADDI, 0, 0, 32'd8, 0, 0, 32'd9, 32'h500, 32'd1, 4'd14);
    checkOutput();
    chk("fi_first_rob", alu_rob_id, 0);
    applyStimulus(OP_ADDI, 0, 0, 32'd8, 0, 0, 32'd9, 32'h500, 32'd1, 4'd14);
    checkOutput();
    chk("fi_second_rob", alu_rob_id, 1);
    checkOutput();
    chk("fi_retry_rob", alu_rob_id, 14);
    chk("fi_retry_v1", alu_v1, 8);
    repeat (RS_SIZE) checkOutput();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1)
        applyStimulus(11'($urandom), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)),
                      $urandom, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)),
                      $urandom, $urandom, $urandom, 4'($urandom));
      if ($urandom_range(0, 2) == 0) cdbAlu(4'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 2) == 0) cdbLsb(4'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 79) == 0) clear = 1'b1;
      checkOutput();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
